// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the adder_arbiter block.
package adder_arb_pkg;

  localparam int ADDER_ARB_WIDTH = 16;
  localparam int SETTLE_CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester-facing bus of adder_arbiter: two request channels and a shared response.
interface adder_arbiter_if
  import adder_arb_pkg::*;
#(
  parameter int WIDTH = ADDER_ARB_WIDTH
);

  // Handshake: a request transfers in the cycle ReqN_Valid && ReqN_Ready are both high;
  // the response has no backpressure and is valid only during the RspN_Valid pulse.
  logic             Req0_Valid;
  logic             Req0_Ready;
  logic [WIDTH-1:0] Req0_A;
  logic [WIDTH-1:0] Req0_B;
  logic             Rsp0_Valid;

  logic             Req1_Valid;
  logic             Req1_Ready;
  logic [WIDTH-1:0] Req1_A;
  logic [WIDTH-1:0] Req1_B;
  logic             Rsp1_Valid;

  logic [WIDTH-1:0] Rsp_Sum;
  logic             Rsp_CO;

  modport master (
    output Req0_Valid, Req0_A, Req0_B, Req1_Valid, Req1_A, Req1_B,
    input  Req0_Ready, Req1_Ready, Rsp0_Valid, Rsp1_Valid, Rsp_Sum, Rsp_CO
  );

  modport slave (
    input  Req0_Valid, Req0_A, Req0_B, Req1_Valid, Req1_A, Req1_B,
    output Req0_Ready, Req1_Ready, Rsp0_Valid, Rsp1_Valid, Rsp_Sum, Rsp_CO
  );

endinterface

// File: rtl/adder_arbiter_rr_arb2.sv
// Two-request round-robin grant logic; the last-grant pointer moves on the done strobe.
module rr_arb2 (
  input  logic Clk,
  input  logic Reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  input  logic done,
  input  logic done_owner,
  output logic gnt0,
  output logic gnt1,
  output logic gnt_sel
);

  // last_q holds the most recent owner; starting at 1 makes requester 0 win the first tie.
  logic last_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      last_q <= 1'b1;
    end else if (done) begin
      last_q <= done_owner;
    end
  end

  always_comb begin
    gnt_sel = 1'b0;
    if (req0 && req1) begin
      gnt_sel = ~last_q;
    end else if (req1) begin
      gnt_sel = 1'b1;
    end
    gnt0 = en && req0 && !gnt_sel;
    gnt1 = en && req1 &&  gnt_sel;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one external adder between two requesters with registered operands and results.
// Optional grant statistics are built when ADDER_ARB_STATS_EN is defined.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int WIDTH  = ADDER_ARB_WIDTH,
  parameter int SETTLE = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  adder_arbiter_if.slave   bus,
  output logic [WIDTH-1:0] Add_A,
  output logic [WIDTH-1:0] Add_B,
  input  logic [WIDTH-1:0] Add_Sum,
  input  logic             Add_CO,
  output logic             Busy,
  output arb_state_t       Dbg_State
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [15:0]      Grant0_Cnt,
  output logic [15:0]      Grant1_Cnt
`endif
);

  localparam logic [SETTLE_CNT_W-1:0] CNT_LOAD = SETTLE_CNT_W'(SETTLE - 1);

  arb_state_t              state_q, state_d;
  logic [SETTLE_CNT_W-1:0] cnt_q;
  logic                    owner_q;
  logic [WIDTH-1:0]        rsp_sum_q;
  logic                    rsp_co_q;
  logic                    gnt0, gnt1, gnt_sel;
  logic                    accept, done, idle;

  assign idle   = (state_q == ST_IDLE);
  assign done   = (state_q == ST_RESP);
  assign accept = gnt0 || gnt1;

  rr_arb2 u_arb (
    .Clk        (Clk),
    .Reset      (Reset),
    .en         (idle),
    .req0       (bus.Req0_Valid),
    .req1       (bus.Req1_Valid),
    .done       (done),
    .done_owner (owner_q),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .gnt_sel    (gnt_sel)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      Add_A     <= '0;
      Add_B     <= '0;
      rsp_sum_q <= '0;
      rsp_co_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        Add_A   <= gnt_sel ? bus.Req1_A : bus.Req0_A;
        Add_B   <= gnt_sel ? bus.Req1_B : bus.Req0_B;
        owner_q <= gnt_sel;
        cnt_q   <= CNT_LOAD;
      end else if (state_q == ST_SETTLE) begin
        // The adder has had SETTLE full cycles on stable inputs when the count reaches 0.
        if (cnt_q == '0) begin
          rsp_sum_q <= Add_Sum;
          rsp_co_q  <= Add_CO;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  assign bus.Req0_Ready = gnt0;
  assign bus.Req1_Ready = gnt1;
  assign bus.Rsp0_Valid = done && !owner_q;
  assign bus.Rsp1_Valid = done &&  owner_q;
  assign bus.Rsp_Sum    = rsp_sum_q;
  assign bus.Rsp_CO     = rsp_co_q;
  assign Busy           = !idle;
  assign Dbg_State      = state_q;

`ifdef ADDER_ARB_STATS_EN
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      Grant0_Cnt <= '0;
      Grant1_Cnt <= '0;
    end else begin
      if (gnt0 && (Grant0_Cnt != 16'hFFFF)) Grant0_Cnt <= Grant0_Cnt + 16'd1;
      if (gnt1 && (Grant1_Cnt != 16'hFFFF)) Grant1_Cnt <= Grant1_Cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Sequencer and round-robin arbiter that shares one combinational 16-bit adder (ripple, carry-lookahead or carry-select) between two requesters. It registers the winning operands onto the adder inputs and holds them for a programmable settle time. It then captures Sum/CO and returns them to the granted requester as a one-cycle response. It sits between the switch/button front end or test logic and the single adder instance, so the adder's inputs and outputs stay registered for fmax analysis.

## Interface
- WIDTH, 16, operand/sum width
- SETTLE, 2, cycles operands are held on the adder before Sum/CO are sampled; legal 1..15
- Clk  in  1  clock
- Reset  in  1  synchronous, active-low
- Req0_Valid  in  1  requester 0 has an operation
- Req0_Ready  out  1  requester 0 operation accepted this cycle
- Req0_A, Req0_B  in  WIDTH  requester 0 operands
- Rsp0_Valid  out  1  one-cycle pulse, result for requester 0
- Req1_Valid / Req1_Ready / Req1_A / Req1_B / Rsp1_Valid: same as requester 0, for requester 1
- Rsp_Sum  out  WIDTH  shared result bus, valid with Rsp0_Valid or Rsp1_Valid
- Rsp_CO  out  1  shared carry-out
- Add_A, Add_B  out  WIDTH  registered operands to the adder
- Add_Sum  in  WIDTH  adder sum
- Add_CO  in  1  adder carry-out
- Busy  out  1  high whenever state is not IDLE
- Grant0_Cnt, Grant1_Cnt  out  16  accepted-operation counters; only present with ADDER_ARB_STATS_EN

## Operation
- States:
  - IDLE → SETTLE: on accept.
  - SETTLE → RESP: when settle counter is 0.
  - RESP → IDLE: unconditionally.
- Arbitration:
  - ReqN_Ready is combinational: asserted only in IDLE, for the winner only.
  - Only one requester is valid → it wins.
  - Both are valid → the requester not granted last time wins.
  - The pointer after reset favours requester 0.
- Accept: Add_A/Add_B ← winner's A/B; grant owner is stored; settle counter ← SETTLE-1.
- SETTLE: counter decrements each cycle. At counter 0, Rsp_Sum/Rsp_CO ← Add_Sum/Add_CO.
- RESP:
  - Owner's RspN_Valid is high for exactly one cycle.
  - Last-grant pointer updates to the owner.
  - There is no response backpressure; requesters must sample on the pulse.
- Requester rules:
  - A, B and Valid must stay stable from Valid rising until Ready.
  - Dropping Valid before Ready is legal and cancels the request with no effect.
  - Valid held high after Ready requests a new operation.
- Arithmetic: Rsp_Sum = (A+B) mod 2^WIDTH. Rsp_CO = bit WIDTH of A+B, taken as-is from the adder.
- Add_A/Add_B, Rsp_Sum and Rsp_CO hold their last values between operations.
- Reset values:
  - State IDLE; pointer favours 0; counter 0.
  - Add_A, Add_B, Rsp_Sum = 0; Rsp_CO = 0.
  - All Ready and Rsp_Valid = 0; Busy = 0; Grant counters = 0.
- Reset mid-operation: the operation is aborted, no response is issued, and Reset takes priority over every other update.

## Timing
- Accept in cycle t.
- Add_A/Add_B are valid from cycle t+1.
- Result is captured at the end of cycle t+SETTLE.
- RspN_Valid is high in cycle t+SETTLE+1.
- Next accept is possible no earlier than cycle t+SETTLE+2, so throughput is one operation per SETTLE+2 cycles.
- Busy is high from t+1 through t+SETTLE+1.
- Ready is never asserted while Busy.
- A request arriving during RESP waits for IDLE.

## Configuration
- ADDER_ARB_STATS_EN defined:
  - Grant0_Cnt/Grant1_Cnt increment on each accept for their requester.
  - They saturate at 16'hFFFF and clear on Reset.
- ADDER_ARB_STATS_EN undefined: the counter ports and logic are absent. All other behaviour is identical.

## Structure
- Package adder_arb_pkg:
  - state enum (IDLE, SETTLE, RESP);
  - default WIDTH constant;
  - SETTLE counter width constant (4 bits).
- Sub-module rr_arb2:
  - two-request round-robin grant logic with a last-grant pointer register;
  - the pointer updates on a grant-done strobe from the sequencer.
- The adder itself is instantiated outside this block and connected through the Add_* ports.

## Test plan
- Single request, SETTLE=2: Req0 A=16'h1234, B=16'h4321 in cycle 0 → Req0_Ready in cycle 0; Rsp0_Valid in cycle 3 only, with Rsp_Sum=16'h5555, Rsp_CO=0; Rsp1_Valid stays 0.
- Overflow: Req1 A=16'hFFFF, B=16'h0001 → Rsp_Sum=16'h0000, Rsp_CO=1; A=16'h8000, B=16'h8000 → Sum 16'h0000, CO=1.
- Contention: after reset, both Valid held high continuously → grants alternate 0,1,0,1; accepts at cycles 0, 4, 8; responses at cycles 3, 7, 11; Busy low only in accept cycles.
- Reset mid-op: Reset low in cycle 2 of a SETTLE=3 operation → no Rsp pulse; Add_A=Add_B=0; next request after release is served by requester 0 first.
- Cancel: Req1_Valid high for one cycle while Busy, then low → no Req1_Ready and no Rsp1_Valid ever.
- Stats (ADDER_ARB_STATS_EN): 5 requester-0 ops and 3 requester-1 ops → Grant0_Cnt=5, Grant1_Cnt=3; preloading the counter to 16'hFFFF via 65535 accepts → it stays at 16'hFFFF.
